data_mem_subword: RTL and testbench
===================================

DATA_MEM_SUBWORD -- requirements
Module: data_mem_subword

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning number of 32-bit words (power of two, >= 4).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request accepted when valid and ready.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 SHALL have port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 SHALL have port req_addr  input  ADDR_W  byte address.
REQ-011 SHALL have port req_wdata  input  32  store data, right-justified.
REQ-012 SHALL have port rsp_valid  output  1  one-cycle response pulse.
REQ-013 SHALL have port rsp_rdata  output  32  load result, zero for stores and errors.
REQ-014 SHALL have port rsp_err  output  1  misaligned, out-of-range or illegal size.

Function
REQ-015 SHALL accept one request per cycle; req_ready high whenever state is RUN.
REQ-016 SHALL produce rsp_valid exactly one cycle after each accepted request; no response backpressure.
REQ-017 SHALL commit stores at the accepting edge, writing only lanes selected by req_addr[1:0] and size (byte: 1 lane, half: lanes addr[1]*2..+1, word: all).
REQ-018 SHALL register load data; rsp_rdata is the selected lane(s) shifted to bit 0 and extended per req_unsigned.
REQ-019 SHALL flag rsp_err and suppress the write when: half with addr[0]=1; word with addr[1:0]!=0; size=11; word index addr[ADDR_W-1:2] >= DEPTH.
REQ-020 SHALL drive rsp_rdata=0 and rsp_err=0 whenever rsp_valid=0.
REQ-021 SHALL return newly written data for a load accepted the cycle after a store to the same word.
REQ-022 SHALL ignore req_* inputs when req_valid=0 or req_ready=0 (no write, no response).
REQ-023 SHALL have states CLEAR and RUN; CLEAR->RUN when clear counter reaches DEPTH-1; RUN->CLEAR only on rst with macro defined.

Reset
REQ-024 SHALL on rst clear rsp_valid, rsp_rdata, rsp_err to 0 at the next edge, discarding any pending response.
REQ-025 SHALL, with rst held, keep req_ready=0; the cycle after rst deasserts follows REQ-030/REQ-031.
REQ-026 SHALL leave memory contents untouched by reset unless DMEM_INIT_CLEAR_EN is defined.

Configuration
REQ-027 SHALL use macro DMEM_INIT_CLEAR_EN.
REQ-028 SHALL, with macro defined, enter CLEAR on reset, zero one word per cycle from index 0 to DEPTH-1 (DEPTH cycles), req_ready=0 throughout, then enter RUN.
REQ-029 SHALL, with macro defined, restart the sweep from index 0 if rst asserts mid-clear.
REQ-030 SHALL, with macro defined, raise req_ready DEPTH cycles after rst deasserts.
REQ-031 SHALL, without macro, enter RUN directly with req_ready=1 the first cycle after rst deasserts; no clear counter synthesised.

Structure
REQ-032 SHALL place size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state type in shared package dmem_pkg.
REQ-033 SHALL implement lane extraction/extension and store-lane enable generation in combinational sub-module dmem_lane_align.

Verification
REQ-034 Store word 0xDEADBEEF @0x10, next cycle load word @0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-035 Store byte 0x80 @0x13, load byte signed @0x13 -> 0xFFFFFF80 and word @0x10 -> 0x80ADBEEF; unsigned byte -> 0x00000080.
REQ-036 Load half @0x11 -> rsp_err=1, rdata=0; store word @0x12 -> rsp_err=1, memory unchanged.
REQ-037 DEPTH=1024: load word @0x1000 -> rsp_err=1; size=11 @0x0 -> rsp_err=1.
REQ-038 rst asserted the cycle after a load accept -> rsp_valid=0 next cycle; contents of @0x10 preserved (macro undefined).
REQ-039 Macro defined, DEPTH=16: after rst, req_ready=0 for 16 cycles, then load word @0x10 -> 0x00000000.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the sub-word data memory: access sizes, controller states
// and the alignment rule used to reject a request.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Size 11 is treated as misaligned so a single flag covers both error kinds.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte enables / replicated write data and
// load lane extraction with sign or zero extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wword,
  output logic [31:0] rdata
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select lanes for the access size and offset within the word
  always_comb begin
    byte_en = 4'b0000;
    wword   = wdata;
    rdata   = 32'h0000_0000;
    byte_s  = rword[{addr_lo, 3'b000} +: 8];
    half_s  = addr_lo[1] ? rword[31:16] : rword[15:0];
    case (size)
      SZ_BYTE: begin
        byte_en = 4'b0001 << addr_lo;
        wword   = {4{wdata[7:0]}};
        rdata   = is_unsigned ? {24'h00_0000, byte_s} : {{24{byte_s[7]}}, byte_s};
      end
      SZ_HALF: begin
        byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword   = {2{wdata[15:0]}};
        rdata   = is_unsigned ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
      end
      SZ_WORD: begin
        byte_en = 4'b1111;
        wword   = wdata;
        rdata   = rword;
      end
      default: begin
        byte_en = 4'b0000;
        wword   = wdata;
        rdata   = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_subword.sv
// Byte/half/word data memory with one-cycle registered responses.
// Optional power-on zeroing sweep enabled by defining DMEM_INIT_CLEAR_EN.
module data_mem_subword
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [31:0]       mem [DEPTH];
  state_t            state_r;
  logic              ready_r;
  logic              rsp_valid_r;
  logic [31:0]       rsp_rdata_r;
  logic              rsp_err_r;

  logic              accept_s;
  logic              err_s;
  logic              store_s;
  logic [ADDR_W-1:0] word_idx_s;
  logic [IDX_W-1:0]  idx_s;
  logic [31:0]       rword_s;
  logic [3:0]        byte_en_s;
  logic [31:0]       wword_s;
  logic [31:0]       load_s;
  logic              clear_wr_s;
  logic [IDX_W-1:0]  clr_idx_s;

`ifdef DMEM_INIT_CLEAR_EN
  logic [IDX_W-1:0]  clr_cnt_r;
  assign clear_wr_s = ~rst & (state_r == ST_CLEAR);
  assign clr_idx_s  = clr_cnt_r;
`else
  assign clear_wr_s = 1'b0;
  assign clr_idx_s  = '0;
`endif

  // Gated by rst so nothing is accepted on the edge that applies reset.
  assign req_ready  = ready_r & ~rst;
  assign accept_s   = req_valid & req_ready;
  assign word_idx_s = {2'b00, req_addr[ADDR_W-1:2]};
  assign idx_s      = req_addr[IDX_W+1:2];
  assign err_s      = misaligned(req_size, req_addr[1:0]) | (word_idx_s >= ADDR_W'(DEPTH));
  assign store_s    = accept_s & req_we & ~err_s;
  assign rword_s    = mem[idx_s];

  dmem_lane_align u_align (
    .size        (req_size),
    .addr_lo     (req_addr[1:0]),
    .is_unsigned (req_unsigned),
    .wdata       (req_wdata),
    .rword       (rword_s),
    .byte_en     (byte_en_s),
    .wword       (wword_s),
    .rdata       (load_s)
  );

  // Memory array: clearing sweep or lane-masked store; no reset on contents
  always_ff @(posedge clk) begin
    if (clear_wr_s) begin
      mem[clr_idx_s] <= 32'h0000_0000;
    end else if (store_s) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en_s[i]) begin
          mem[idx_s][8*i +: 8] <= wword_s[8*i +: 8];
        end
      end
    end
  end

  // Controller state, ready and registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_r     <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
`ifdef DMEM_INIT_CLEAR_EN
      state_r     <= ST_CLEAR;
      clr_cnt_r   <= '0;
`else
      state_r     <= ST_RUN;
`endif
    end else begin
      case (state_r)
        ST_CLEAR: begin
`ifdef DMEM_INIT_CLEAR_EN
          if (clr_cnt_r == IDX_W'(DEPTH - 1)) begin
            state_r <= ST_RUN;
            ready_r <= 1'b1;
          end else begin
            clr_cnt_r <= clr_cnt_r + IDX_W'(1);
            ready_r   <= 1'b0;
          end
`else
          state_r <= ST_RUN;
          ready_r <= 1'b1;
`endif
        end
        ST_RUN: begin
          ready_r <= 1'b1;
        end
        default: begin
          state_r <= ST_RUN;
          ready_r <= 1'b0;
        end
      endcase
      rsp_valid_r <= accept_s;
      rsp_err_r   <= accept_s & err_s;
      rsp_rdata_r <= (accept_s & ~req_we & ~err_s) ? load_s : 32'h0000_0000;
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_data_mem_subword.sv
// Randomized self-checking bench for data_mem_subword against a byte-array model.
// Builds with or without DMEM_INIT_CLEAR_EN.
module tb_data_mem_subword;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 32;
`ifdef DMEM_INIT_CLEAR_EN
  localparam int READY_WAIT = DEPTH;
`else
  localparam int READY_WAIT = 1;
`endif

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  int checks = 0;
  int errors = 0;
  logic [7:0] ref_mem [64];

  data_mem_subword #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Behavioural model: byte-addressed memory, sizes as byte counts.
  task automatic ref_access(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic e, output logic [31:0] r);
    int n;
    longint v;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    e = (size == 2'd3) || ((addr % n) != 0) || ((addr / 4) >= DEPTH);
    r = 32'h0;
    if (!e) begin
      if (we) begin
        for (int k = 0; k < n; k++) ref_mem[6'(addr + k)] = 8'(wdata >> (8 * k));
      end else begin
        v = 0;
        for (int k = 0; k < n; k++) v = v | (longint'(ref_mem[6'(addr + k)]) << (8 * k));
        if (!uns && (((v >> (8 * n - 1)) & 1) == 1)) v = v - (longint'(1) << (8 * n));
        r = v[31:0];
      end
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] got);
    logic e;
    logic [31:0] r;
    ref_access(we, size, uns, addr, wdata, e, r);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    check_eq("ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_eq("rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("rsp_err", 32'(rsp_err), 32'(e));
    check_eq("rsp_rdata", rsp_rdata, r);
    got = rsp_rdata;
  endtask

  task automatic idle_cycle();
    req_valid = 1'b0; req_we = 1'b1; req_size = 2'(($urandom_range(0, 2)));
    req_addr = 32'($urandom_range(0, 63)); req_wdata = $urandom;
    @(posedge clk);
    #1;
    check_eq("idle_valid", 32'(rsp_valid), 32'h0);
    check_eq("idle_rdata", rsp_rdata, 32'h0);
    check_eq("idle_err", 32'(rsp_err), 32'h0);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < READY_WAIT; i++) begin
      if (req_ready !== 1'b0) begin
        check_eq("ready_low", 32'(req_ready), 32'h0);
        break;
      end
      @(posedge clk);
      #1;
    end
    check_eq("ready_up", 32'(req_ready), 32'h1);
`ifdef DMEM_INIT_CLEAR_EN
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
`endif
  endtask

  initial begin
    logic [31:0] got;
    logic [1:0]  sz;
    logic [31:0] a;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", 32'(req_ready), 32'h0);
    check_eq("rst_valid", 32'(rsp_valid), 32'h0);
    check_eq("rst_rdata", rsp_rdata, 32'h0);
    check_eq("rst_err", 32'(rsp_err), 32'h0);
    rst = 1'b0;
    wait_ready();

    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, got);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got);
    check_eq("load_after_store", got, 32'hDEADBEEF);
    do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_0080, got);
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, got);
    check_eq("byte_signed", got, 32'hFFFFFF80);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got);
    check_eq("word_merged", got, 32'h80ADBEEF);
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, got);
    check_eq("byte_unsigned", got, 32'h00000080);
    do_req(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, got);
    check_eq("half_misaligned_data", got, 32'h0);
    do_req(1'b1, 2'b10, 1'b0, 32'h12, 32'h12345678, got);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got);
    check_eq("word_unchanged", got, 32'h80ADBEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, got);
    do_req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, got);
    idle_cycle();

    // Reset right after a load accept drops the next response.
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got);
    rst = 1'b1;
    #1;
    check_eq("rst_ready_comb", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1;
    check_eq("rst_drops_rsp", 32'(rsp_valid), 32'h0);
    rst = 1'b0;
    wait_ready();
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got);
`ifdef DMEM_INIT_CLEAR_EN
    check_eq("cleared_word", got, 32'h0);
`else
    check_eq("preserved_word", got, 32'h80ADBEEF);
`endif

    for (int w = 0; w < 16; w++) do_req(1'b1, 2'b10, 1'b0, 32'(w * 4), $urandom, got);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        idle_cycle();
      end else begin
        sz = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) a = 32'h1000 | $urandom;
        else a = 32'($urandom_range(0, 63));
        do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, got);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
